// File: rtl/mem_sched.sv
// mem_sched: request/grant scheduler for the shared external SRAM port.
// Arbitrates VGA, CPU and DMA requesters. It drives the active-low SRAM strobes,
// the address and the write data, and returns registered read data with
// per-requester grant and done pulses.
module mem_sched #(
    parameter int unsigned DATAWIDTH     = 16,
    parameter int unsigned ADDRWIDTH     = 16,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vga_req,
    input  logic                 cpu_req,
    input  logic                 dma_req,
    input  logic                 vga_we,
    input  logic                 cpu_we,
    input  logic                 dma_we,
    input  logic [ADDRWIDTH-1:0] vga_addr,
    input  logic [ADDRWIDTH-1:0] cpu_addr,
    input  logic [ADDRWIDTH-1:0] dma_addr,
    input  logic [DATAWIDTH-1:0] cpu_wdata,
    input  logic [DATAWIDTH-1:0] dma_wdata,
    input  logic [DATAWIDTH-1:0] EXT_MEM_DATA,
    output logic                 vga_gnt,
    output logic                 cpu_gnt,
    output logic                 dma_gnt,
    output logic                 vga_done,
    output logic                 cpu_done,
    output logic                 dma_done,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 CE,
    output logic                 OE,
    output logic                 WE,
    output logic [ADDRWIDTH-1:0] EXT_MEM_ADDR,
    output logic [DATAWIDTH-1:0] DOUT_SRAM,
    output logic                 busy,
    output logic [1:0]           owner
);

    localparam int unsigned CYC_W = 3;
    localparam int unsigned STV_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VGA  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DMA  = 2'd3;

    logic [1:0]           state, state_nxt;
    logic [CYC_W-1:0]     cyc_cnt, cyc_nxt;
    logic [STV_W-1:0]     starve_cnt, starve_nxt;
    logic                 acc_we, acc_we_nxt;
    logic [2:0]           gnt_q, gnt_nxt;
    logic [2:0]           done_q, done_nxt;
    logic                 ce_nxt, oe_nxt, we_nxt, busy_nxt;
    logic [1:0]           owner_nxt;
    logic [ADDRWIDTH-1:0] addr_nxt;
    logic [DATAWIDTH-1:0] dout_nxt, rdata_nxt;

    logic [1:0]           winner;
    logic                 sel_we;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;

    function automatic logic [2:0] owner_onehot(input logic [1:0] o);
        case (o)
            OWN_VGA: return 3'b001;
            OWN_CPU: return 3'b010;
            OWN_DMA: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign vga_gnt  = gnt_q[0];
    assign cpu_gnt  = gnt_q[1];
    assign dma_gnt  = gnt_q[2];
    assign vga_done = done_q[0];
    assign cpu_done = done_q[1];
    assign dma_done = done_q[2];

    // Fixed priority VGA > CPU > DMA, with DMA promoted over CPU once starved
    always_comb begin
        winner    = OWN_NONE;
        sel_we    = 1'b0;
        sel_addr  = vga_addr;
        sel_wdata = '0;
        if (vga_req) begin
            winner = OWN_VGA;
        end else if (cpu_req && !(dma_req && starve_cnt == STV_W'(STARVE_LIMIT))) begin
            winner = OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end
        case (winner)
            OWN_CPU: begin
                sel_we    = cpu_we;
                sel_addr  = cpu_addr;
                sel_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                sel_we    = dma_we;
                sel_addr  = dma_addr;
                sel_wdata = dma_wdata;
            end
            // VGA is read-only: its write enable is masked off
            default: sel_we = vga_we & 1'b0;
        endcase
    end

    // Next-state and next-output logic for IDLE -> ACCESS -> DONE
    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc_cnt;
        starve_nxt = starve_cnt;
        acc_we_nxt = acc_we;
        owner_nxt  = owner;
        addr_nxt   = EXT_MEM_ADDR;
        rdata_nxt  = rdata;
        dout_nxt   = '0;
        ce_nxt     = 1'b1;
        oe_nxt     = 1'b1;
        we_nxt     = 1'b1;
        busy_nxt   = 1'b0;
        gnt_nxt    = '0;
        done_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (!dma_req) begin
                    starve_nxt = '0;
                end
                if (winner != OWN_NONE) begin
                    state_nxt  = ST_ACCESS;
                    cyc_nxt    = '0;
                    acc_we_nxt = sel_we;
                    owner_nxt  = winner;
                    addr_nxt   = sel_addr;
                    dout_nxt   = sel_we ? sel_wdata : '0;
                    ce_nxt     = 1'b0;
                    oe_nxt     = sel_we;
                    we_nxt     = !sel_we;
                    busy_nxt   = 1'b1;
                    gnt_nxt    = owner_onehot(winner);
                    if (winner == OWN_CPU && dma_req && starve_cnt != STV_W'(STARVE_LIMIT)) begin
                        starve_nxt = starve_cnt + STV_W'(1);
                    end else if (winner == OWN_DMA) begin
                        starve_nxt = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cyc_cnt == CYC_W'(ACCESS_CYCLES - 1)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = owner_onehot(owner);
                    if (!acc_we) begin
                        rdata_nxt = EXT_MEM_DATA;
                    end
                end else begin
                    cyc_nxt  = cyc_cnt + CYC_W'(1);
                    ce_nxt   = 1'b0;
                    oe_nxt   = acc_we;
                    we_nxt   = !acc_we;
                    dout_nxt = DOUT_SRAM;
                    busy_nxt = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cyc_cnt      <= '0;
            starve_cnt   <= '0;
            acc_we       <= 1'b0;
            owner        <= OWN_NONE;
            EXT_MEM_ADDR <= '0;
            DOUT_SRAM    <= '0;
            rdata        <= '0;
            CE           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            busy         <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
        end else begin
            state        <= state_nxt;
            cyc_cnt      <= cyc_nxt;
            starve_cnt   <= starve_nxt;
            acc_we       <= acc_we_nxt;
            owner        <= owner_nxt;
            EXT_MEM_ADDR <= addr_nxt;
            DOUT_SRAM    <= dout_nxt;
            rdata        <= rdata_nxt;
            CE           <= ce_nxt;
            OE           <= oe_nxt;
            WE           <= we_nxt;
            busy         <= busy_nxt;
            gnt_q        <= gnt_nxt;
            done_q       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: randomized bench for mem_sched with a timeline reference model.
// The model treats each granted access as an event schedule in cycle numbers:
// gnt at g, strobes for AC cycles, done at g+AC, next arbitration at g+AC+1.
module tb_mem_sched;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned AC = 2;
    localparam int unsigned SL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req    [3];
    logic          we_i   [3];
    logic [AW-1:0] addr_i [3];
    logic [DW-1:0] wd_i   [3];
    logic [DW-1:0] ext_data;

    logic          vga_gnt, cpu_gnt, dma_gnt, vga_done, cpu_done, dma_done;
    logic [DW-1:0] rdata, dout_sram;
    logic          ce, oe, we, busy;
    logic [AW-1:0] ext_addr;
    logic [1:0]    owner;

    mem_sched #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .vga_req(req[0]), .cpu_req(req[1]), .dma_req(req[2]),
        .vga_we(we_i[0]), .cpu_we(we_i[1]), .dma_we(we_i[2]),
        .vga_addr(addr_i[0]), .cpu_addr(addr_i[1]), .dma_addr(addr_i[2]),
        .cpu_wdata(wd_i[1]), .dma_wdata(wd_i[2]),
        .EXT_MEM_DATA(ext_data),
        .vga_gnt(vga_gnt), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .vga_done(vga_done), .cpu_done(cpu_done), .dma_done(dma_done),
        .rdata(rdata), .CE(ce), .OE(oe), .WE(we),
        .EXT_MEM_ADDR(ext_addr), .DOUT_SRAM(dout_sram),
        .busy(busy), .owner(owner)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          cyc = 0;
    bit          valid = 1'b0;
    int          mode = 0;
    bit          rec_on = 1'b0;
    int          rec_q[$];

    // Reference model state
    int            free_at, g_cyc, m_starve;
    bit            active;
    int            t_own;
    logic          t_we;
    logic [DW-1:0] t_wd;
    logic [2:0]    e_gnt, e_done;
    logic          e_ce, e_oe, e_we, e_busy;
    logic [1:0]    e_owner;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout, e_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outputs for the next cycle from the inputs of the current one
    task automatic model_step();
        int w;
        int k;
        if (rst) begin
            e_gnt = '0; e_done = '0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_busy = 1'b0;
            e_owner = '0; e_addr = '0; e_dout = '0; e_rdata = '0;
            active = 1'b0; free_at = cyc + 1; m_starve = 0;
            return;
        end
        e_gnt = '0; e_done = '0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_busy = 1'b0; e_dout = '0;
        if (cyc >= free_at) begin
            w = 0;
            if (req[0]) w = 1;
            else if (req[1] && !(req[2] && m_starve == int'(SL))) w = 2;
            else if (req[2]) w = 3;
            if (!req[2]) m_starve = 0;
            if (w == 2 && req[2]) m_starve = (m_starve < int'(SL)) ? m_starve + 1 : int'(SL);
            if (w == 3) m_starve = 0;
            if (w != 0) begin
                active  = 1'b1;
                g_cyc   = cyc + 1;
                free_at = cyc + int'(AC) + 2;
                t_own   = w;
                t_we    = (w == 1) ? 1'b0 : we_i[w-1];
                t_wd    = wd_i[w-1];
                e_addr  = addr_i[w-1];
                e_owner = 2'(w);
                e_gnt[w-1] = 1'b1;
            end
        end
        if (active) begin
            k = cyc + 1 - g_cyc;
            if (k < int'(AC)) begin
                e_ce = 1'b0; e_oe = t_we; e_we = !t_we; e_busy = 1'b1;
                e_dout = t_we ? t_wd : '0;
            end else begin
                e_done[t_own-1] = 1'b1;
                if (!t_we) e_rdata = ext_data;
                active = 1'b0;
            end
        end
    endtask

    // Requester behaviour: hold until grant, optionally re-request, rarely withdraw
    task automatic drive();
        for (int r = 0; r < 3; r++) begin
            if (e_gnt[r]) begin
                if (!(mode == 1 && r != 0) && $urandom_range(3) != 0) req[r] = 1'b0;
            end else if (!req[r]) begin
                if ((mode == 1 && r != 0) ||
                    (mode == 0 && $urandom_range((r == 0) ? 5 : 2) == 0)) begin
                    req[r]    = 1'b1;
                    we_i[r]   = 1'($urandom_range(1));
                    addr_i[r] = AW'($urandom);
                    wd_i[r]   = DW'($urandom);
                end
            end else if (mode == 0 && $urandom_range(15) == 0) begin
                req[r] = 1'b0;
            end
        end
        ext_data = DW'($urandom);
    endtask

    task automatic step(input logic rst_v);
        @(posedge clk);
        #1;
        if (valid) begin
            chk("gnt",     32'({dma_gnt, cpu_gnt, vga_gnt}),    32'(e_gnt));
            chk("done",    32'({dma_done, cpu_done, vga_done}), 32'(e_done));
            chk("strobes", 32'({ce, oe, we}),                   32'({e_ce, e_oe, e_we}));
            chk("busy",    32'(busy),      32'(e_busy));
            chk("owner",   32'(owner),     32'(e_owner));
            chk("addr",    32'(ext_addr),  32'(e_addr));
            chk("dout",    32'(dout_sram), 32'(e_dout));
            chk("rdata",   32'(rdata),     32'(e_rdata));
        end
        if (rec_on && (vga_gnt || cpu_gnt || dma_gnt)) rec_q.push_back(int'(owner));
        drive();
        rst = rst_v;
        model_step();
        valid = 1'b1;
        cyc++;
    endtask

    initial begin
        int exp_ord [11] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3, 2};
        rst = 1'b1;
        ext_data = '0;
        for (int r = 0; r < 3; r++) begin
            req[r] = 1'b0; we_i[r] = 1'b0; addr_i[r] = '0; wd_i[r] = '0;
        end
        repeat (3) step(1'b1);
        repeat (1500) step(1'($urandom_range(199) == 0));

        // CPU and DMA held continuously: DMA must break through every SL CPU grants
        mode = 1;
        req[0] = 1'b0;
        step(1'b1);
        step(1'b1);
        rec_on = 1'b1;
        for (int i = 0; i < 400 && rec_q.size() < 11; i++) step(1'b0);
        rec_on = 1'b0;
        chk("starve_grant_count", 32'(rec_q.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < rec_q.size()) chk("starve_order", 32'(rec_q[i]), 32'(exp_ord[i]));
        end

        mode = 0;
        repeat (800) step(1'($urandom_range(99) == 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
